// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: width, parity, stop bits, bit order, valid/ready output.
// Optional `RX_MAJORITY_EN: each bit is a 2-of-3 vote around the bit centre.
module uart_rx_param #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
`ifdef RX_MAJORITY_EN
    localparam logic [CW-1:0] SAMP = CW'(CLK_DIV / 2 + 1);
    localparam logic [CW-1:0] M0   = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] M1   = CW'(CLK_DIV / 2);
`else
    localparam logic [CW-1:0] SAMP = CW'(CLK_DIV / 2);
`endif
    localparam logic [3:0] NBITS = 4'(DATA_BITS);
    localparam logic [3:0] NSTOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q;
    logic                 sync1_q;
    logic                 sync2_q;
    logic                 prev_q;
    logic [1:0]           fill_q;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 bit_v;
    logic                 samp_pt;
    logic                 wrap;
    logic                 fall;
    logic                 commit;
    logic                 accept;

`ifdef RX_MAJORITY_EN
    logic maj0_q;
    logic maj1_q;
    assign bit_v = (maj0_q & maj1_q) | (maj0_q & sync2_q) | (maj1_q & sync2_q);
`else
    assign bit_v = sync2_q;
`endif

    // prev_q only arms once sync2_q carries a real line sample, so a line
    // held low through reset release never looks like a start edge.
    assign fall    = prev_q & ~sync2_q;
    assign samp_pt = cnt_q == SAMP;
    assign wrap    = cnt_q == LAST;
    assign commit  = (state_q == S_STOP) && samp_pt && (bit_cnt_q == NSTOP);
    assign accept  = valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b0;
            fill_q     <= '0;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef RX_MAJORITY_EN
            maj0_q     <= 1'b1;
            maj1_q     <= 1'b1;
`endif
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            prev_q  <= sync2_q & fill_q[1];
`ifdef RX_MAJORITY_EN
            if (cnt_q == M0) maj0_q <= sync2_q;
            if (cnt_q == M1) maj1_q <= sync2_q;
`endif
            if (accept) begin
                valid <= 1'b0;
                if (!commit) overrun <= 1'b0;
            end
            if (state_q != S_IDLE) cnt_q <= wrap ? '0 : cnt_q + 1'b1;

            unique case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        state_q <= S_START;
                        busy    <= 1'b1;
                        cnt_q   <= '0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (samp_pt && bit_v) begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (wrap) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                    end
                end
                S_DATA: begin
                    if (samp_pt) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (LSB_FIRST != 0)
                            shift_q <= {bit_v, shift_q[DATA_BITS-1:1]};
                        else
                            shift_q <= {shift_q[DATA_BITS-2:0], bit_v};
                    end
                    if (wrap && bit_cnt_q == NBITS) begin
                        bit_cnt_q <= '0;
                        state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (samp_pt) perr_q <= ^{shift_q, bit_v} ^ (PARITY == 1);
                    if (wrap) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (commit) begin
                        state_q   <= S_IDLE;
                        busy      <= 1'b0;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        if (valid && !ready) begin
                            overrun <= 1'b1;
                        end else begin
                            valid      <= 1'b1;
                            data       <= shift_q;
                            parity_err <= perr_q;
                            frame_err  <= ferr_q | ~bit_v;
                        end
                    end else if (samp_pt) begin
                        ferr_q    <= ferr_q | ~bit_v;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver and the next generation of the existing fixed 8N1 receiver. It adds configurable data width, parity, stop bits and bit order. It validates the start bit, flags parity and framing errors, and presents each received word on a valid/ready handshake with overrun detection. It sits between the rx pad and a downstream consumer such as a command parser or FIFO.

Parameters:
CLK_DIV, 434, clock cycles per bit (115200 baud at 50 MHz); legal range 8..65535
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
LSB_FIRST, 1, bit order: 1 = first data bit received is data[0]; 0 = first data bit received is data[DATA_BITS-1]

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_i  in  1  asynchronous serial line; idles high
data  out  DATA_BITS  received word; held stable while valid = 1
valid  out  1  word available
ready  in  1  consumer accepts the word when valid && ready
parity_err  out  1  parity mismatch for the word on data; qualified by valid; 0 when PARITY = 0
frame_err  out  1  a stop bit was sampled low for the word on data; qualified by valid
overrun  out  1  sticky: a frame completed while the previous word was still pending
busy  out  1  FSM not in IDLE

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (rst).
- Reset values:
  - data = 0, valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0.
  - FSM = IDLE; baud counter and bit counter = 0.
  - Both synchroniser flops reset to 1 (idle line), so no edge is detected at reset release.
- rx_i passes through a 2-flop synchroniser. A falling edge is detected on the synchronised line (previous = 1, current = 0).
- If the line is held low through reset release, no edge is detected; reception starts only after the line goes high and then low again.
- Baud counter counts 0..CLK_DIV-1 and wraps. It is cleared on entering START.
- Sample point: count == CLK_DIV/2 (integer division).
- FSM states:
  - IDLE: on falling edge -> START, busy = 1.
  - START: at sample point, line = 1 -> IDLE (glitch rejected, nothing reported). Line = 0 -> continue; at count wrap -> DATA.
  - DATA: sample one bit at each sample point and shift it into the data shift register per LSB_FIRST. After DATA_BITS bits, at count wrap -> PARITY if PARITY != 0, else STOP.
  - PARITY: sample at sample point. Error if the XOR of data bits and the parity bit is 0 for odd parity, or 1 for even parity. At wrap -> STOP.
  - STOP: sample each stop bit at its sample point; frame_err if any stop bit is 0. At the sample point of the final stop bit, commit the word and go to IDLE immediately, without waiting for the wrap. This allows back-to-back frames and roughly half a bit of baud tolerance.
- Commit (registered): valid, data, parity_err and frame_err update in the cycle after the final stop sample point.
  - Latency from the rx_i start-bit falling edge to valid: 2 + (1 + DATA_BITS + P + STOP_BITS - 1)·CLK_DIV + CLK_DIV/2 + 1 cycles, where P = 1 if PARITY != 0, else 0.
- Words with frame_err or parity_err are still delivered.
- Handshake:
  - valid stays high until valid && ready. Then valid = 0 in the next cycle, unless a commit occurs in the same cycle.
  - data, parity_err and frame_err do not change while valid = 1, except on a commit coincident with acceptance.
- Commit while valid && !ready: the new word is dropped, the old word is kept, and overrun = 1.
- Commit in the same cycle as valid && ready: the new word is loaded, valid stays 1, overrun is unchanged.
- overrun clears on the next handshake (valid && ready) after it is set, or on rst.
- rst asserted mid-frame aborts the frame: no valid, and all outputs return to their reset values in the next cycle.
- A falling edge seen while not in IDLE is ignored.

Optional Feature:
RX_MAJORITY_EN
- Defined: every sampled bit (start, data, parity, stop) is the 2-of-3 majority of the synchronised line at counts CLK_DIV/2-1, CLK_DIV/2 and CLK_DIV/2+1. The decision takes effect at CLK_DIV/2+1, so valid moves 1 cycle later than the undefined case. Start-bit rejection also uses the majority value.
- Not defined: single sample at CLK_DIV/2, exactly as in Behaviour.

Test Plan:
1. Defaults with CLK_DIV = 16, ready held 1: send 0xA5 in 8N1 -> one valid pulse with data = 0xA5, parity_err = 0, frame_err = 0; valid appears exactly at the latency formula value.
2. PARITY = 2, DATA_BITS = 7: send 0x55 with correct parity bit 0 -> parity_err = 0. Send 0x55 with parity bit 1 -> parity_err = 1, data = 0x55.
3. STOP_BITS = 2: send 0x3C with second stop bit driven 0 -> frame_err = 1, data = 0x3C, valid asserted; FSM returns to IDLE.
4. Glitch: pulse rx_i low for 4 cycles with CLK_DIV = 16 -> stays in IDLE after the start check; valid never asserts; busy high for under 1 bit time.
5. ready held 0: send 0x11, then 0x22 -> data stays 0x11, overrun = 1. Pulse ready -> valid = 0, overrun = 0. Repeat with ready asserted exactly in the 0x22 commit cycle -> data = 0x22, valid = 1, overrun = 0.
6. rst asserted after 3 data bits of 0xFF, then a full 0x81 frame sent -> only 0x81 is delivered and all outputs return to 0 at rst. With LSB_FIRST = 0, the same 0x81 frame yields the bit-reversed word 0x81 (symmetric) and 0x01 sent yields 0x80.
